// File: rtl/mem_addr_gen_pkg.sv
// Shared definitions for the memory-stage address generator: addressing modes,
// stack pointer index and index width helper.
package mem_addr_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_POSTINC = 2'b01,
        MODE_PREDEC  = 2'b10,
        MODE_DISP    = 2'b11
    } mode_e;

    localparam int SP_IDX = 0;

    // Keeps index ports at least one bit wide even for a single-pointer build.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_gen_if.sv
// Bundle of request, pointer load/readback and memory address handshake signals.
// The master side is the decode/memory environment, the slave side is mem_addr_gen.
interface mem_addr_gen_if
    import mem_addr_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_PTRS   = 4,
    parameter int DISP_WIDTH = 6
);
    localparam int IDX_W = idxWidth(NUM_PTRS);

    logic                  req_valid;
    logic                  req_ready;
    logic [IDX_W-1:0]      req_sel;
    logic [1:0]            req_mode;
    logic [DISP_WIDTH-1:0] req_disp;
    logic                  ptr_wr_en;
    logic [IDX_W-1:0]      ptr_wr_idx;
    logic [ADDR_WIDTH-1:0] ptr_wr_data;
    logic [IDX_W-1:0]      ptr_rd_idx;
    logic [ADDR_WIDTH-1:0] ptr_rd_data;
    logic                  addr_valid;
    logic                  addr_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  bounds_fault;

    modport master (
        output req_valid, req_sel, req_mode, req_disp,
        output ptr_wr_en, ptr_wr_idx, ptr_wr_data, ptr_rd_idx, addr_ready,
        input  req_ready, ptr_rd_data, addr_valid, mem_addr, bounds_fault
    );

    modport slave (
        input  req_valid, req_sel, req_mode, req_disp,
        input  ptr_wr_en, ptr_wr_idx, ptr_wr_data, ptr_rd_idx, addr_ready,
        output req_ready, ptr_rd_data, addr_valid, mem_addr, bounds_fault
    );

endinterface

// File: rtl/mem_addr_gen_ptr_file.sv
// Pointer register array: one update port, one external load port that wins on
// an index collision, and two combinational read ports.
module mem_ptr_file
    import mem_addr_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    NUM_PTRS   = 4,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET   = 16'hFFFF,
    parameter int                    IDX_W      = idxWidth(NUM_PTRS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  upd_en_i,
    input  logic [IDX_W-1:0]      upd_idx_i,
    input  logic [ADDR_WIDTH-1:0] upd_data_i,
    input  logic                  ld_en_i,
    input  logic [IDX_W-1:0]      ld_idx_i,
    input  logic [ADDR_WIDTH-1:0] ld_data_i,
    input  logic [IDX_W-1:0]      rd0_idx_i,
    output logic [ADDR_WIDTH-1:0] rd0_data_o,
    input  logic [IDX_W-1:0]      rd1_idx_i,
    output logic [ADDR_WIDTH-1:0] rd1_data_o
);

    logic [ADDR_WIDTH-1:0] ptr_q [NUM_PTRS];
    logic [ADDR_WIDTH-1:0] ptr_d [NUM_PTRS];

    // An external load to the same index overrides the mode-driven update.
    always_comb begin
        for (int i = 0; i < NUM_PTRS; i++) begin
            ptr_d[i] = ptr_q[i];
            if (ld_en_i && (ld_idx_i == IDX_W'(i))) begin
                ptr_d[i] = ld_data_i;
            end else if (upd_en_i && (upd_idx_i == IDX_W'(i))) begin
                ptr_d[i] = upd_data_i;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PTRS; i++) begin
                ptr_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NUM_PTRS; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign rd0_data_o = ptr_q[rd0_idx_i];
    assign rd1_data_o = ptr_q[rd1_idx_i];

endmodule

// File: rtl/mem_addr_gen.sv
// Memory-stage address generator with four addressing modes and a registered
// valid/ready address output. Optional stack bound check: MEM_ADDR_BOUNDS_CHK_EN.
module mem_addr_gen
    import mem_addr_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    NUM_PTRS   = 4,
    parameter int                    DISP_WIDTH = 6,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET   = 16'hFFFF
`ifdef MEM_ADDR_BOUNDS_CHK_EN
    ,
    parameter logic [ADDR_WIDTH-1:0] SP_LIMIT   = 16'h0100
`endif
) (
    input logic           clock,
    input logic           reset_n,
    mem_addr_gen_if.slave bus
);

    localparam int IDX_W = idxWidth(NUM_PTRS);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    mode_e                 mode;
    logic                  reqReady;
    logic                  accept;
    logic                  updEn;
    logic [ADDR_WIDTH-1:0] selPtr;
    logic [ADDR_WIDTH-1:0] nextAddr;
    logic [ADDR_WIDTH-1:0] updValue;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic                  addrValid_q, addrValid_d;

    assign mode     = mode_e'(bus.req_mode);
    assign reqReady = !addrValid_q || bus.addr_ready;
    assign accept   = bus.req_valid && reqReady;

    mem_ptr_file #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_PTRS   (NUM_PTRS),
        .SP_RESET   (SP_RESET),
        .IDX_W      (IDX_W)
    ) u_ptr_file (
        .clock      (clock),
        .reset_n    (reset_n),
        .upd_en_i   (updEn),
        .upd_idx_i  (bus.req_sel),
        .upd_data_i (updValue),
        .ld_en_i    (bus.ptr_wr_en),
        .ld_idx_i   (bus.ptr_wr_idx),
        .ld_data_i  (bus.ptr_wr_data),
        .rd0_idx_i  (bus.req_sel),
        .rd0_data_o (selPtr),
        .rd1_idx_i  (bus.ptr_rd_idx),
        .rd1_data_o (bus.ptr_rd_data)
    );

    // Address and write-back value per mode; wrap-around is plain modulo arithmetic.
    always_comb begin
        nextAddr = selPtr;
        updValue = selPtr;
        updEn    = 1'b0;
        case (mode)
            MODE_DIRECT: begin
                nextAddr = selPtr;
            end
            MODE_POSTINC: begin
                updValue = selPtr + ONE;
                updEn    = accept;
            end
            MODE_PREDEC: begin
                nextAddr = selPtr - ONE;
                updValue = selPtr - ONE;
                updEn    = accept;
            end
            MODE_DISP: begin
                nextAddr = selPtr + ADDR_WIDTH'(bus.req_disp);
            end
            default: begin
                nextAddr = selPtr;
            end
        endcase
    end

    always_comb begin
        memAddr_d   = memAddr_q;
        addrValid_d = addrValid_q;
        if (accept) begin
            memAddr_d   = nextAddr;
            addrValid_d = 1'b1;
        end else if (bus.addr_ready) begin
            addrValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            memAddr_q   <= '0;
            addrValid_q <= 1'b0;
        end else begin
            memAddr_q   <= memAddr_d;
            addrValid_q <= addrValid_d;
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.addr_valid = addrValid_q;
    assign bus.mem_addr   = memAddr_q;

`ifdef MEM_ADDR_BOUNDS_CHK_EN
    logic boundsFault_q, boundsFault_d;
    logic spAccess;

    // Stack underflow below the limit or overflow out of the top both latch the fault.
    assign spAccess = accept && (bus.req_sel == IDX_W'(SP_IDX));

    always_comb begin
        boundsFault_d = boundsFault_q;
        if (spAccess && (mode == MODE_PREDEC) && (nextAddr < SP_LIMIT)) begin
            boundsFault_d = 1'b1;
        end
        if (spAccess && (mode == MODE_POSTINC) && (selPtr == '1)) begin
            boundsFault_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            boundsFault_q <= 1'b0;
        end else begin
            boundsFault_q <= boundsFault_d;
        end
    end

    assign bus.bounds_fault = boundsFault_q;
`else
    assign bus.bounds_fault = 1'b0;
`endif

endmodule

// File: doc/mem_addr_gen.md
# mem_addr_gen

Parametrised memory-stage address generator that replaces the fixed four-way pointer select. It holds NUM_PTRS address pointers, with index 0 as the stack pointer, and supports four addressing modes: direct, post-increment, pre-decrement and displacement. It writes updated pointers back internally and presents a registered address to the data memory through a valid/ready handshake. It sits in the memory pipeline stage between decode-supplied control and the data memory port.

## Interface
- ADDR_WIDTH, 16, width of pointers and address
- NUM_PTRS, 4, number of pointers; index 0 = stack pointer
- DISP_WIDTH, 6, unsigned displacement width
- SP_RESET, 16'hFFFF, stack pointer reset value (other pointers reset to 0)

Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  address request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_sel  in  $clog2(NUM_PTRS)  pointer index
- req_mode  in  2  00 direct, 01 post-inc, 10 pre-dec, 11 displacement
- req_disp  in  DISP_WIDTH  displacement, used only in mode 11
- ptr_wr_en  in  1  external pointer load
- ptr_wr_idx  in  $clog2(NUM_PTRS)  pointer to load
- ptr_wr_data  in  ADDR_WIDTH  load value
- ptr_rd_idx  in  $clog2(NUM_PTRS)  debug/readback select
- ptr_rd_data  out  ADDR_WIDTH  combinational value of the selected pointer
- addr_valid  out  1  mem_addr valid
- addr_ready  in  1  memory consumes mem_addr
- mem_addr  out  ADDR_WIDTH  registered memory address
- bounds_fault  out  1  sticky stack-bound fault (only with the macro; tied 0 otherwise)

## Operation
- Accept condition: req_valid && req_ready. req_ready = !addr_valid || addr_ready, which gives a single-entry output register with full throughput.
- Address and pointer update on accept, with P = ptr[req_sel]:
  - direct: mem_addr <= P; no update.
  - post-inc: mem_addr <= P; ptr <= P+1.
  - pre-dec: mem_addr <= P-1; ptr <= P-1.
  - displacement: mem_addr <= P + zero-extended req_disp; no update.
- Arithmetic is modulo 2^ADDR_WIDTH. 16'hFFFF+1 wraps to 0, and 0-1 wraps to 16'hFFFF. Wrapping is silent except for the bounds check below.
- Same-cycle ptr_wr_en and accepted update to the same index: the external load wins and the update is dropped. The address is still computed from the pre-load P.
- ptr_wr_en to a different index than the update: both take effect.
- A request issued the cycle after an update or load sees the new pointer value. No bypass is needed, because the update is registered.
- When not accepted, mem_addr holds and addr_valid holds while !addr_ready.
- ptr_rd_data reflects the registered pointer. A same-cycle write is not forwarded.

## Timing
- Latency: 1 cycle from accept to addr_valid/mem_addr.
- Back-to-back accepts are allowed every cycle while addr_ready=1.
- Reset values (asynchronous, reset_n=0):
  - addr_valid=0, mem_addr=0
  - ptr[0]=SP_RESET, other pointers=0
  - bounds_fault=0, and req_ready=1 after release
- Reset asserted mid-handshake discards the pending address and any in-flight update.
- addr_valid must not drop without addr_ready. mem_addr must be stable while addr_valid && !addr_ready.

## Configuration
- MEM_ADDR_BOUNDS_CHK_EN defined:
  - Adds parameter SP_LIMIT (default 16'h0100).
  - Any accepted pre-dec on index 0 producing an address < SP_LIMIT sets bounds_fault. So does a post-inc on index 0 that wraps from 16'hFFFF.
  - bounds_fault is sticky until reset. The access still proceeds.
- Without the macro: no comparator, and bounds_fault is a constant 0.

## Structure
- Shared package mem_addr_pkg holds:
  - the mode encodings MODE_DIRECT, MODE_POSTINC, MODE_PREDEC, MODE_DISP
  - SP_IDX=0
- Sub-module mem_ptr_file is the NUM_PTRS×ADDR_WIDTH register array. It has one update port, one load port with load priority, and two combinational read ports (request select and debug).
- Top level contains the address adder, handshake logic, output register and optional bounds logic.

## Test plan
- Reset then idle: ptr_rd_data idx0=16'hFFFF, idx1=0; addr_valid=0, req_ready=1.
- Load X (idx1)=16'h1000, then 3 back-to-back post-inc on idx1 with addr_ready=1: mem_addr=1000,1001,1002 on consecutive cycles; X ends at 16'h1003.
- Pre-dec on SP from 16'hFFFF twice: mem_addr=FFFE then FFFD, with SP=FFFD. Pre-dec at SP=0 gives mem_addr=FFFF.
- Displacement Z=16'hFFF0 with disp=6'h3F: mem_addr=16'h002F; Z unchanged.
- addr_ready=0 for 3 cycles with a pending address: mem_addr and addr_valid held, req_ready=0, and pointer not updated by the stalled request. Release gives one transfer.
- Same-cycle post-inc idx2 (Y=16'h0020) plus ptr_wr idx2=16'h5555: mem_addr=0020 and Y=5555. With the macro, pre-dec SP to 16'h00FF with SP_LIMIT=16'h0100 sets bounds_fault=1 and it stays set.
